// File: rtl/ex_stage.sv
// ex_stage -- execute stage of a 5-stage MIPS-style pipeline.
// It computes the ALU, shift and HI/LO-move results in a single cycle.
// It also owns the architectural HI/LO registers.
// An optional multi-cycle restoring divider (DIV/DIVU) is built only when the
// macro EX_STAGE_DIV_EN is defined. Without it, the divide opcodes behave as
// NOPs and stallreq_o stays low.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  shamt_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        cancel_i,
  output logic [4:0]  wd_o,
  output logic [31:0] wdata_o,
  output logic        wreg_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OP_AND  = 8'h24;
  localparam logic [7:0] OP_OR   = 8'h25;
  localparam logic [7:0] OP_XOR  = 8'h26;
  localparam logic [7:0] OP_NOR  = 8'h27;
  localparam logic [7:0] OP_ADDU = 8'h21;
  localparam logic [7:0] OP_SUBU = 8'h23;
  localparam logic [7:0] OP_SLT  = 8'h2A;
  localparam logic [7:0] OP_SLTU = 8'h2B;
  localparam logic [7:0] OP_SLL  = 8'h7C;
  localparam logic [7:0] OP_SRL  = 8'h02;
  localparam logic [7:0] OP_SRA  = 8'h03;
  localparam logic [7:0] OP_MFHI = 8'h10;
  localparam logic [7:0] OP_MFLO = 8'h12;
  localparam logic [7:0] OP_MTHI = 8'h11;
  localparam logic [7:0] OP_MTLO = 8'h13;
`ifdef EX_STAGE_DIV_EN
  localparam logic [7:0] OP_DIV  = 8'h1A;
  localparam logic [7:0] OP_DIVU = 8'h1B;
`endif

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] alu_res;
  logic        alu_wr;

  // Divider interface to the HI/LO update logic and to pipeline control.
  logic        div_wr;
  logic [31:0] div_lo;
  logic [31:0] div_hi;
  logic        div_stall;

  // Single-cycle result selection; opcodes that write no GPR leave alu_wr low.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; otherwise an unlisted case infers a latch.
    alu_res = '0;
    alu_wr  = 1'b0;
    case (aluop_i)
      OP_AND:  begin alu_res = reg1_i & reg2_i;    alu_wr = 1'b1; end
      OP_OR:   begin alu_res = reg1_i | reg2_i;    alu_wr = 1'b1; end
      OP_XOR:  begin alu_res = reg1_i ^ reg2_i;    alu_wr = 1'b1; end
      OP_NOR:  begin alu_res = ~(reg1_i | reg2_i); alu_wr = 1'b1; end
      OP_ADDU: begin alu_res = reg1_i + reg2_i;    alu_wr = 1'b1; end
      OP_SUBU: begin alu_res = reg1_i - reg2_i;    alu_wr = 1'b1; end
      OP_SLT: begin
        alu_res = {31'b0, ($signed(reg1_i) < $signed(reg2_i))};
        alu_wr  = 1'b1;
      end
      OP_SLTU: begin
        alu_res = {31'b0, (reg1_i < reg2_i)};
        alu_wr  = 1'b1;
      end
      OP_SLL:  begin alu_res = reg2_i << shamt_i;  alu_wr = 1'b1; end
      OP_SRL:  begin alu_res = reg2_i >> shamt_i;  alu_wr = 1'b1; end
      OP_SRA:  begin alu_res = $signed(reg2_i) >>> shamt_i; alu_wr = 1'b1; end
      OP_MFHI: begin alu_res = hi_q;               alu_wr = 1'b1; end
      OP_MFLO: begin alu_res = lo_q;               alu_wr = 1'b1; end
      default: ;
    endcase
  end

  // Outputs to the memory stage are forced quiet while reset is held.
  always_comb begin
    wd_o       = 5'd0;
    wdata_o    = 32'd0;
    wreg_o     = 1'b0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wdata_o    = alu_res;
      wreg_o     = wreg_i & alu_wr;
      stallreq_o = div_stall;
    end
  end

  // Next HI/LO: a move-to instruction, or a finished divide, takes effect at the edge.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (aluop_i == OP_MTHI) hi_d = reg1_i;
    if (aluop_i == OP_MTLO) lo_d = reg1_i;
    if (div_wr) begin
      hi_d = div_hi;
      lo_d = div_lo;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

`ifdef EX_STAGE_DIV_EN
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] quo_q;      // dividend magnitude shifting out, quotient shifting in
  logic [31:0] rem_q;      // partial remainder
  logic [31:0] dvs_q;      // divisor magnitude
  logic        neg_quo_q;
  logic        neg_rem_q;

  logic        is_div;
  logic        is_signed;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [32:0] shifted;
  logic [33:0] trial;

  assign is_div    = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign is_signed = (aluop_i == OP_DIV);
  assign mag_a     = (is_signed && reg1_i[31]) ? -reg1_i : reg1_i;
  assign mag_b     = (is_signed && reg2_i[31]) ? -reg2_i : reg2_i;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign shifted = {rem_q, quo_q[31]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  // Divider control and datapath; cancel and reset both abandon the operation.
  always_ff @(posedge clk) begin
    // NOTE: only control state is reset; datapath registers are always loaded before they are read.
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else if (cancel_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (is_div) begin
            if (reg2_i == 32'd0) begin
              quo_q     <= '0;
              rem_q     <= '0;
              neg_quo_q <= 1'b0;
              neg_rem_q <= 1'b0;
              state_q   <= DIV_DONE;
            end else begin
              quo_q     <= mag_a;
              rem_q     <= '0;
              dvs_q     <= mag_b;
              neg_quo_q <= is_signed & (reg1_i[31] ^ reg2_i[31]);
              neg_rem_q <= is_signed & reg1_i[31];
              cnt_q     <= '0;
              state_q   <= DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          quo_q <= {quo_q[30:0], ~trial[33]};
          rem_q <= trial[33] ? shifted[31:0] : trial[31:0];
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= DIV_DONE;
        end
        DIV_DONE: state_q <= DIV_IDLE;
        default:  state_q <= DIV_IDLE;
      endcase
    end
  end

  // Stall covers the accepting IDLE cycle plus every BUSY cycle, never DONE.
  always_comb begin
    div_stall = 1'b0;
    if (!cancel_i) begin
      case (state_q)
        DIV_IDLE: div_stall = is_div;
        DIV_BUSY: div_stall = 1'b1;
        default:  div_stall = 1'b0;
      endcase
    end
  end

  assign div_wr = (state_q == DIV_DONE) && !cancel_i;
  assign div_lo = neg_quo_q ? -quo_q : quo_q;
  assign div_hi = neg_rem_q ? -rem_q : rem_q;
`else
  logic unused_cancel;

  assign unused_cancel = cancel_i;
  assign div_stall     = 1'b0;
  assign div_wr        = 1'b0;
  assign div_lo        = '0;
  assign div_hi        = '0;
`endif

endmodule
